// File: rtl/musb_memwb_skid_register.sv
`default_nettype none
// ============================================================================
// Module      : musb_memwb_skid_register
// Description : MEM->WB pipeline register with a one-entry skid buffer.
//               Two storage slots (head + skid) give full throughput with a
//               ready signal that is decoded purely from registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module musb_memwb_skid_register #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 5,
    parameter int ZERO_REG_WE_KILL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic                  mem_flush,
    input  logic                  wb_flush,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic [DATA_WIDTH-1:0] mem_alu_data,
    input  logic [ADDR_WIDTH-1:0] mem_gpr_wa,
    input  logic                  mem_mem_to_gpr_select,
    input  logic                  mem_gpr_we,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_read_data,
    output logic [DATA_WIDTH-1:0] wb_alu_data,
    output logic [ADDR_WIDTH-1:0] wb_gpr_wa,
    output logic                  wb_mem_to_gpr_select,
    output logic                  wb_gpr_we,
    output logic [DATA_WIDTH-1:0] wb_gpr_wd
);

    // Occupancy states: EMPTY (no entry), HALF (head only), FULL (head+skid)
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_HALF  = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]            r_state;

    logic [DATA_WIDTH-1:0] r_head_read_data;
    logic [DATA_WIDTH-1:0] r_head_alu_data;
    logic [ADDR_WIDTH-1:0] r_head_wa;
    logic                  r_head_sel;
    logic                  r_head_we;

    logic [DATA_WIDTH-1:0] r_skid_read_data;
    logic [DATA_WIDTH-1:0] r_skid_alu_data;
    logic [ADDR_WIDTH-1:0] r_skid_wa;
    logic                  r_skid_sel;
    logic                  r_skid_we;

    logic                  w_mem_we;
    logic                  w_accept;
    logic                  w_consume;

    // The write enable is cleaned on entry so the stored value is final.
    generate
        if (ZERO_REG_WE_KILL != 0) begin : g_zero_kill
            assign w_mem_we = mem_gpr_we & (mem_gpr_wa != '0);
        end else begin : g_no_kill
            assign w_mem_we = mem_gpr_we;
        end
    endgenerate

    // Ready and valid decode from registered state only.
    assign mem_ready = (r_state != c_ST_FULL);
    assign wb_valid  = (r_state != c_ST_EMPTY);

    assign w_accept  = mem_valid & mem_ready & ~mem_flush;
    assign w_consume = wb_valid & wb_ready;

    // Occupancy FSM and head/skid storage; flush empties without touching data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_ST_EMPTY;
            r_head_read_data <= '0;
            r_head_alu_data  <= '0;
            r_head_wa        <= '0;
            r_head_sel       <= 1'b0;
            r_head_we        <= 1'b0;
            r_skid_read_data <= '0;
            r_skid_alu_data  <= '0;
            r_skid_wa        <= '0;
            r_skid_sel       <= 1'b0;
            r_skid_we        <= 1'b0;
        end else if (wb_flush) begin
            r_state <= c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_head_read_data <= mem_read_data;
                        r_head_alu_data  <= mem_alu_data;
                        r_head_wa        <= mem_gpr_wa;
                        r_head_sel       <= mem_mem_to_gpr_select;
                        r_head_we        <= w_mem_we;
                        r_state          <= c_ST_HALF;
                    end
                end
                c_ST_HALF: begin
                    if (w_accept && w_consume) begin
                        r_head_read_data <= mem_read_data;
                        r_head_alu_data  <= mem_alu_data;
                        r_head_wa        <= mem_gpr_wa;
                        r_head_sel       <= mem_mem_to_gpr_select;
                        r_head_we        <= w_mem_we;
                    end else if (w_accept) begin
                        r_skid_read_data <= mem_read_data;
                        r_skid_alu_data  <= mem_alu_data;
                        r_skid_wa        <= mem_gpr_wa;
                        r_skid_sel       <= mem_mem_to_gpr_select;
                        r_skid_we        <= w_mem_we;
                        r_state          <= c_ST_FULL;
                    end else if (w_consume) begin
                        r_state          <= c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    if (w_consume) begin
                        r_head_read_data <= r_skid_read_data;
                        r_head_alu_data  <= r_skid_alu_data;
                        r_head_wa        <= r_skid_wa;
                        r_head_sel       <= r_skid_sel;
                        r_head_we        <= r_skid_we;
                        r_state          <= c_ST_HALF;
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                end
            endcase
        end
    end

    assign wb_read_data         = r_head_read_data;
    assign wb_alu_data          = r_head_alu_data;
    assign wb_gpr_wa            = r_head_wa;
    assign wb_mem_to_gpr_select = r_head_sel;
    assign wb_gpr_we            = wb_valid & r_head_we;
    assign wb_gpr_wd            = r_head_sel ? r_head_read_data : r_head_alu_data;

endmodule
`default_nettype wire

// File: tb/tb_musb_memwb_skid_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_musb_memwb_skid_register
// Description : Self-checking bench for the MEM->WB skid register. A queue
//               model tracks stored beats; directed literal checks pin it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_musb_memwb_skid_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_flush, wb_flush, wb_ready;
    logic        mem_ready;
    logic [31:0] mem_read_data, mem_alu_data;
    logic [4:0]  mem_gpr_wa;
    logic        mem_mem_to_gpr_select, mem_gpr_we;
    logic        wb_valid;
    logic [31:0] wb_read_data, wb_alu_data, wb_gpr_wd;
    logic [4:0]  wb_gpr_wa;
    logic        wb_mem_to_gpr_select, wb_gpr_we;

    // Second instance with zero-register kill disabled (shares stimulus)
    logic        nk_mem_ready, nk_wb_valid, nk_sel, nk_we;
    logic [31:0] nk_rd, nk_alu, nk_wd;
    logic [4:0]  nk_wa;

    // Wide instance
    logic        w_valid, w_mem_ready, w_wb_valid, w_sel_o, w_we_o;
    logic [63:0] w_rd_i, w_alu_i, w_rd_o, w_alu_o, w_wd_o;
    logic [5:0]  w_wa_i, w_wa_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    musb_memwb_skid_register dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_flush(mem_flush), .wb_flush(wb_flush),
        .mem_read_data(mem_read_data), .mem_alu_data(mem_alu_data),
        .mem_gpr_wa(mem_gpr_wa), .mem_mem_to_gpr_select(mem_mem_to_gpr_select),
        .mem_gpr_we(mem_gpr_we), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_read_data(wb_read_data), .wb_alu_data(wb_alu_data),
        .wb_gpr_wa(wb_gpr_wa), .wb_mem_to_gpr_select(wb_mem_to_gpr_select),
        .wb_gpr_we(wb_gpr_we), .wb_gpr_wd(wb_gpr_wd)
    );

    musb_memwb_skid_register #(.ZERO_REG_WE_KILL(0)) dut_nk (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(nk_mem_ready),
        .mem_flush(mem_flush), .wb_flush(wb_flush),
        .mem_read_data(mem_read_data), .mem_alu_data(mem_alu_data),
        .mem_gpr_wa(mem_gpr_wa), .mem_mem_to_gpr_select(mem_mem_to_gpr_select),
        .mem_gpr_we(mem_gpr_we), .wb_valid(nk_wb_valid), .wb_ready(wb_ready),
        .wb_read_data(nk_rd), .wb_alu_data(nk_alu), .wb_gpr_wa(nk_wa),
        .wb_mem_to_gpr_select(nk_sel), .wb_gpr_we(nk_we), .wb_gpr_wd(nk_wd)
    );

    musb_memwb_skid_register #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) dut_w (
        .clk(clk), .rst(rst), .mem_valid(w_valid), .mem_ready(w_mem_ready),
        .mem_flush(1'b0), .wb_flush(1'b0),
        .mem_read_data(w_rd_i), .mem_alu_data(w_alu_i), .mem_gpr_wa(w_wa_i),
        .mem_mem_to_gpr_select(1'b1), .mem_gpr_we(1'b1),
        .wb_valid(w_wb_valid), .wb_ready(1'b1),
        .wb_read_data(w_rd_o), .wb_alu_data(w_alu_o), .wb_gpr_wa(w_wa_o),
        .wb_mem_to_gpr_select(w_sel_o), .wb_gpr_we(w_we_o), .wb_gpr_wd(w_wd_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: ordered queue of stored beats -----
    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wa;
        logic        sel;
        logic        we;
    } beat_t;

    beat_t q[$];
    beat_t last;
    bit    model_ok = 0;

    always @(posedge clk) begin
        beat_t b;
        bit    cons, acc;
        if (rst) begin
            q.delete();
            last     = '{32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
            model_ok = 1;
        end else if (wb_flush) begin
            q.delete();
        end else begin
            cons = (q.size() > 0) && wb_ready;
            acc  = mem_valid && (q.size() < 2) && !mem_flush;
            b    = '{mem_read_data, mem_alu_data, mem_gpr_wa,
                     mem_mem_to_gpr_select, mem_gpr_we};
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(b);
            if (q.size() > 0) last = q[0];
        end
    end

    // Compare all outputs of the main instance against the model every cycle
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_valid", wb_valid, q.size() > 0);
            chk("m_ready", mem_ready, q.size() < 2);
            chk("m_rd",    wb_read_data, last.rd);
            chk("m_alu",   wb_alu_data, last.alu);
            chk("m_wa",    wb_gpr_wa, last.wa);
            chk("m_sel",   wb_mem_to_gpr_select, last.sel);
            chk("m_we",    wb_gpr_we, (q.size() > 0) && last.we && (last.wa != 0));
            chk("m_wd",    wb_gpr_wd, last.sel ? last.rd : last.alu);
        end
    end

    // ---------------- directed stimulus -----------------------------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [31:0] rd, input logic [31:0] alu,
                        input logic [4:0] wa, input logic sel, input logic we);
        mem_valid = 1'b1;
        mem_read_data = rd;
        mem_alu_data = alu;
        mem_gpr_wa = wa;
        mem_mem_to_gpr_select = sel;
        mem_gpr_we = we;
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b1; mem_flush = 1'b0; wb_flush = 1'b0;
        wb_ready = 1'b0; mem_read_data = 32'h77; mem_alu_data = 32'h66;
        mem_gpr_wa = 5'd3; mem_mem_to_gpr_select = 1'b0; mem_gpr_we = 1'b1;
        w_valid = 1'b0; w_rd_i = '0; w_alu_i = '0; w_wa_i = '0;
        cyc(); cyc();
        // reset state, beat presented during reset ignored
        chk("rst_valid", wb_valid, 1'b0);
        chk("rst_ready", mem_ready, 1'b1);
        chk("rst_alu", wb_alu_data, 32'h0);
        chk("rst_we", wb_gpr_we, 1'b0);
        rst = 1'b0; mem_valid = 1'b0;
        cyc();
        chk("rst_no_accept", wb_valid, 1'b0);

        // streaming A..D with wb_ready high
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(32'(i), 32'(17 * (i + 1)), 5'(i + 1), 1'b0, 1'b1);
            cyc();
            chk("str_valid", wb_valid, 1'b1);
            chk("str_alu", wb_alu_data, 32'(17 * (i + 1)));
            chk("str_wa", wb_gpr_wa, 5'(i + 1));
            chk("str_ready", mem_ready, 1'b1);
        end
        mem_valid = 1'b0;
        cyc();
        chk("str_drain", wb_valid, 1'b0);
        chk("str_hold", wb_alu_data, 32'h44);

        // backpressure A, B, C
        wb_ready = 1'b0;
        beat(0, 32'hA0, 5'd1, 1'b0, 1'b1); cyc();
        beat(0, 32'hB0, 5'd2, 1'b0, 1'b1); cyc();
        chk("bp_full", mem_ready, 1'b0);
        chk("bp_head", wb_alu_data, 32'hA0);
        beat(0, 32'hC0, 5'd3, 1'b0, 1'b1); cyc();
        chk("bp_c_ignored", wb_alu_data, 32'hA0);
        wb_ready = 1'b1; cyc();
        chk("bp_b", wb_alu_data, 32'hB0);
        chk("bp_b_valid", wb_valid, 1'b1);
        cyc();
        chk("bp_c", wb_alu_data, 32'hC0);
        mem_valid = 1'b0; cyc();
        chk("bp_empty", wb_valid, 1'b0);

        // flush in FULL with a beat presented
        wb_ready = 1'b0;
        beat(0, 32'hE1, 5'd1, 1'b0, 1'b1); cyc();
        beat(0, 32'hE2, 5'd2, 1'b0, 1'b1); cyc();
        beat(0, 32'hE3, 5'd3, 1'b0, 1'b1); wb_flush = 1'b1; cyc();
        chk("fl_valid", wb_valid, 1'b0);
        chk("fl_we", wb_gpr_we, 1'b0);
        chk("fl_ready", mem_ready, 1'b1);
        chk("fl_hold", wb_alu_data, 32'hE1);
        wb_flush = 1'b0; wb_ready = 1'b1; mem_flush = 1'b1;
        beat(0, 32'h99, 5'd4, 1'b0, 1'b1); cyc();
        chk("mfl_drop", wb_valid, 1'b0);
        mem_flush = 1'b0; mem_valid = 1'b0; cyc();
        chk("mfl_never", wb_valid, 1'b0);

        // zero register write kill, both parameter settings
        beat(0, 32'hDEAD, 5'd0, 1'b0, 1'b1); cyc();
        chk("z_valid", wb_valid, 1'b1);
        chk("z_we_kill", wb_gpr_we, 1'b0);
        chk("z_we_nokill", nk_we, 1'b1);
        chk("z_wd", wb_gpr_wd, 32'hDEAD);
        mem_valid = 1'b0; cyc();

        // write-data mux
        beat(32'h1234, 32'h5678, 5'd5, 1'b1, 1'b1); cyc();
        chk("mux_sel1", wb_gpr_wd, 32'h1234);
        beat(32'h1234, 32'h5678, 5'd6, 1'b0, 1'b1); cyc();
        chk("mux_sel0", wb_gpr_wd, 32'h5678);
        mem_valid = 1'b0; cyc();

        // reset while FULL
        wb_ready = 1'b0;
        beat(32'h1, 32'h2, 5'd7, 1'b1, 1'b1); cyc();
        beat(32'h3, 32'h4, 5'd8, 1'b0, 1'b1); cyc();
        chk("rf_full", mem_ready, 1'b0);
        rst = 1'b1; cyc();
        chk("rf_valid", wb_valid, 1'b0);
        chk("rf_ready", mem_ready, 1'b1);
        chk("rf_rd", wb_read_data, 32'h0);
        chk("rf_alu", wb_alu_data, 32'h0);
        chk("rf_wa", wb_gpr_wa, 5'd0);
        chk("rf_sel", wb_mem_to_gpr_select, 1'b0);
        chk("rf_wd", wb_gpr_wd, 32'h0);
        chk("rf_we", wb_gpr_we, 1'b0);
        rst = 1'b0; mem_valid = 1'b0; cyc();

        // wide instance
        w_valid = 1'b1; w_rd_i = 64'hFFFF_0000_0000_FFFF;
        w_alu_i = 64'h0123_4567_89AB_CDEF; w_wa_i = 6'd63; cyc();
        chk("w_valid", w_wb_valid, 1'b1);
        chk("w_rd", w_rd_o, 64'hFFFF_0000_0000_FFFF);
        chk("w_alu", w_alu_o, 64'h0123_4567_89AB_CDEF);
        chk("w_wa", w_wa_o, 6'd63);
        chk("w_wd", w_wd_o, 64'hFFFF_0000_0000_FFFF);
        chk("w_we", w_we_o, 1'b1);
        w_valid = 1'b0; cyc();
        chk("w_drain", w_wb_valid, 1'b0);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
